// File: rtl/score_items_pkg.sv
// Shared types for the score-items transmit path: record layout and FSM state encoding.
package score_items_pkg;

    localparam int DEF_W_ITEM  = 8;
    localparam int DEF_W_SCORE = 32;

    typedef struct packed {
        logic [DEF_W_ITEM-1:0] age;
        logic [DEF_W_ITEM-1:0] iq;
        logic [DEF_W_ITEM-1:0] shoesize;
    } score_item_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } tx_state_e;

endpackage

// File: rtl/score_items_tx_if.sv
// Producer, scorer and result signals of score_items_tx.
// master = producer/scorer side, slave = score_items_tx itself.
interface score_items_tx_if
    import score_items_pkg::*;
#(
    parameter int W_ITEM  = DEF_W_ITEM,
    parameter int W_SCORE = DEF_W_SCORE
);
    logic               in_valid;
    logic               in_ready;
    logic [W_ITEM-1:0]  in_age;
    logic [W_ITEM-1:0]  in_iq;
    logic [W_ITEM-1:0]  in_shoesize;

    logic               out_valid;
    logic [W_ITEM-1:0]  out_age;
    logic [W_ITEM-1:0]  out_iq;
    logic [W_ITEM-1:0]  out_shoesize;

    logic               score_valid;
    logic [W_SCORE-1:0] score;

    logic               res_valid;
    logic [W_SCORE-1:0] res_score;
    logic               res_timeout;

    modport master (
        output in_valid, in_age, in_iq, in_shoesize, score_valid, score,
        input  in_ready, out_valid, out_age, out_iq, out_shoesize,
        input  res_valid, res_score, res_timeout
    );

    modport slave (
        input  in_valid, in_age, in_iq, in_shoesize, score_valid, score,
        output in_ready, out_valid, out_age, out_iq, out_shoesize,
        output res_valid, res_score, res_timeout
    );

endinterface

// File: rtl/score_items_fifo.sv
// Synchronous record FIFO with registered occupancy count; head is read combinationally.
module score_items_fifo
    import score_items_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  score_item_t            wr_data,
    output score_item_t            rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    score_item_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries below count are ever read out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/score_items_tx.sv
// Score-items transmitter: buffers records, presents one at a time, awaits score or timeout.
// Optional SCORE_ITEMS_TX_STATS_EN adds saturating sent/timeout counters.
//
//   state | meaning
//   IDLE  | waiting for a buffered record; pops it into out_* when present
//   DRIVE | record presented (out_valid), counting cycles until score or timeout
//   RESP  | one-cycle result pulse on res_valid
module score_items_tx
    import score_items_pkg::*;
#(
    parameter int W_ITEM  = DEF_W_ITEM,
    parameter int W_SCORE = DEF_W_SCORE,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    score_items_tx_if.slave   bus,
    output logic              busy
`ifdef SCORE_ITEMS_TX_STATS_EN
    ,
    output logic [15:0]       stat_sent,
    output logic [15:0]       stat_timeouts
`endif
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_TC = CW'(TIMEOUT - 1);

    tx_state_e             state_q, state_d;
    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
    score_item_t           out_item_q, out_item_d;
    logic [W_SCORE-1:0]    res_score_q, res_score_d;
    logic                  res_timeout_q, res_timeout_d;

    score_item_t           fifo_wr, fifo_head;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    assign fifo_wr.age      = bus.in_age;
    assign fifo_wr.iq       = bus.in_iq;
    assign fifo_wr.shoesize = bus.in_shoesize;
    assign fifo_push        = bus.in_valid && bus.in_ready;

    score_items_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (fifo_wr),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        out_item_d    = out_item_q;
        res_score_d   = res_score_q;
        res_timeout_d = res_timeout_q;
        fifo_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    out_item_d = fifo_head;
                    wait_cnt_d = '0;
                    state_d    = DRIVE;
                end
            end
            DRIVE: begin
                // A score arriving on the last allowed cycle still counts as a response.
                if (bus.score_valid) begin
                    res_score_d   = bus.score;
                    res_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (wait_cnt_q == WAIT_TC) begin
                    res_score_d   = '0;
                    res_timeout_d = 1'b1;
                    state_d       = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            RESP: begin
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
            default: begin
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            out_item_q    <= '0;
            res_score_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            out_item_q    <= out_item_d;
            res_score_q   <= res_score_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    // Outputs are forced low while rst is held, before the reset edge lands.
    assign bus.in_ready     = !rst && !fifo_full;
    assign bus.out_valid    = !rst && (state_q == DRIVE);
    assign bus.out_age      = rst ? '0 : W_ITEM'(out_item_q.age);
    assign bus.out_iq       = rst ? '0 : W_ITEM'(out_item_q.iq);
    assign bus.out_shoesize = rst ? '0 : W_ITEM'(out_item_q.shoesize);
    assign bus.res_valid    = !rst && (state_q == RESP);
    assign bus.res_score    = rst ? '0 : res_score_q;
    assign bus.res_timeout  = !rst && res_timeout_q;
    assign busy             = !rst && ((state_q != IDLE) || (fifo_count != '0));

`ifdef SCORE_ITEMS_TX_STATS_EN
    logic [15:0] stat_sent_q, stat_sent_d;
    logic [15:0] stat_to_q, stat_to_d;

    always_comb begin
        stat_sent_d = stat_sent_q;
        stat_to_d   = stat_to_q;
        if (fifo_pop && (stat_sent_q != 16'hFFFF)) begin
            stat_sent_d = stat_sent_q + 16'd1;
        end
        if ((state_q == RESP) && res_timeout_q && (stat_to_q != 16'hFFFF)) begin
            stat_to_d = stat_to_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_sent_q <= '0;
            stat_to_q   <= '0;
        end else begin
            stat_sent_q <= stat_sent_d;
            stat_to_q   <= stat_to_d;
        end
    end

    assign stat_sent     = rst ? '0 : stat_sent_q;
    assign stat_timeouts = rst ? '0 : stat_to_q;
`endif

endmodule

// File: tb/tb_score_items_tx.sv
// Bench for score_items_tx: directed scenarios plus a random phase, checked against a
// transaction-level model (record queue, per-record response plan, result rule).
module tb_score_items_tx;
    import score_items_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    typedef struct {
        int          resp_at;
        logic [31:0] score;
    } plan_t;

    logic clk;
    logic rst;
    logic busy;
`ifdef SCORE_ITEMS_TX_STATS_EN
    logic [15:0] stat_sent;
    logic [15:0] stat_timeouts;
`endif

    score_items_tx_if #(.W_ITEM(8), .W_SCORE(32)) tx ();

    score_items_tx #(
        .W_ITEM  (8),
        .W_SCORE (32),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (tx.slave),
        .busy          (busy)
`ifdef SCORE_ITEMS_TX_STATS_EN
        ,
        .stat_sent     (stat_sent),
        .stat_timeouts (stat_timeouts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc     = 0;
    int          n_results = 0;
    int          drive_len = 0;
    int          resp_at   = 0;
    logic [31:0] resp_score = '0;
    int          last_push_cyc = 0;
    int          last_pres_cyc = 0;
    bit          noise_en = 1'b0;
    score_item_t cur;
    score_item_t src_q [$];
    score_item_t exp_q [$];
    plan_t       plan_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic score_item_t mk_rec(input int a, input int i, input int s);
        score_item_t r;
        r.age      = 8'(a);
        r.iq       = 8'(i);
        r.shoesize = 8'(s);
        return r;
    endfunction

    function automatic score_item_t rand_rec();
        return mk_rec(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)));
    endfunction

    // One cycle: observe at the falling edge, act as scorer and producer, advance.
    task automatic step();
        logic        exp_busy;
        int          exp_len;
        logic [31:0] exp_score;
        logic        exp_to;
        plan_t       pl;
        if (tx.out_valid === 1'b1) begin
            if (drive_len == 0) begin
                check("rec_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) cur = exp_q.pop_front();
                if (plan_q.size() != 0) begin
                    pl = plan_q.pop_front();
                    resp_at    = pl.resp_at;
                    resp_score = pl.score;
                end else begin
                    resp_at    = int'($urandom_range(1, TIMEOUT + 4));
                    resp_score = $urandom;
                end
                last_pres_cyc = cyc;
            end
            drive_len++;
            check("out_rec", 64'({tx.out_age, tx.out_iq, tx.out_shoesize}), 64'(cur));
            check("drive_bound", 64'(drive_len <= TIMEOUT), 64'd1);
        end
        exp_busy = (exp_q.size() != 0) || (drive_len != 0);
        check("busy", 64'(busy), 64'(exp_busy));
        if (tx.res_valid === 1'b1) begin
            check("res_has_rec", 64'(drive_len != 0), 64'd1);
            if (resp_at <= TIMEOUT) begin
                exp_len = resp_at; exp_score = resp_score; exp_to = 1'b0;
            end else begin
                exp_len = TIMEOUT; exp_score = '0; exp_to = 1'b1;
            end
            check("drive_len", 64'(drive_len), 64'(exp_len));
            check("res_score", 64'(tx.res_score), 64'(exp_score));
            check("res_timeout", 64'(tx.res_timeout), 64'(exp_to));
            check("res_out_low", 64'(tx.out_valid), 64'd0);
            n_results++;
            drive_len = 0;
        end
        check("in_ready", 64'(tx.in_ready), 64'(exp_q.size() < DEPTH));
        if (tx.out_valid === 1'b1 && drive_len == resp_at) begin
            tx.score_valid = 1'b1;
            tx.score       = resp_score;
        end else if (noise_en && tx.out_valid !== 1'b1 && $urandom_range(0, 3) == 0) begin
            tx.score_valid = 1'b1;
            tx.score       = $urandom;
        end else begin
            tx.score_valid = 1'b0;
            tx.score       = $urandom;
        end
        if (src_q.size() != 0 && (!noise_en || $urandom_range(0, 1) == 1)) begin
            tx.in_valid    = 1'b1;
            tx.in_age      = src_q[0].age;
            tx.in_iq       = src_q[0].iq;
            tx.in_shoesize = src_q[0].shoesize;
        end else begin
            tx.in_valid    = 1'b0;
        end
        if (tx.in_valid === 1'b1 && tx.in_ready === 1'b1) begin
            exp_q.push_back(src_q.pop_front());
            last_push_cyc = cyc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_until(input string tag, input int target, input int budget);
        int b;
        b = budget;
        while (n_results < target && b > 0) begin
            step();
            b--;
        end
        check(tag, 64'(n_results), 64'(target));
    endtask

    initial begin
        rst            = 1'b1;
        tx.in_valid    = 1'b0;
        tx.in_age      = '0;
        tx.in_iq       = '0;
        tx.in_shoesize = '0;
        tx.score_valid = 1'b0;
        tx.score       = '0;

        // Reset state
        repeat (3) begin
            @(negedge clk);
            check("rst_in_ready", 64'(tx.in_ready), 64'd0);
            check("rst_out_valid", 64'(tx.out_valid), 64'd0);
            check("rst_res_valid", 64'(tx.res_valid), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
        end
        rst = 1'b0;
        #1;
        check("post_rst_res_score", 64'(tx.res_score), 64'd0);
        check("post_rst_out_age", 64'(tx.out_age), 64'd0);

        // Single record, score 139 on the second DRIVE cycle
        src_q.push_back(mk_rec(30, 100, 9));
        plan_q.push_back('{2, 32'd139});
        run_until("t1_done", n_results + 1, 30);
        check("t1_latency", 64'(last_pres_cyc - last_push_cyc), 64'd2);
        check("t1_res_hold", 64'(tx.res_score), 64'd139);
        check("t1_res_pulse", 64'(tx.res_valid), 64'd0);

        // Scorer silent: full-length timeout
        src_q.push_back(rand_rec());
        plan_q.push_back('{TIMEOUT + 5, 32'd0});
        run_until("timeout_done", n_results + 1, 40);
        check("timeout_idle_busy", 64'(busy), 64'd0);
        check("timeout_hold", 64'(tx.res_timeout), 64'd1);

        // Score arrives on the final allowed cycle
        src_q.push_back(rand_rec());
        plan_q.push_back('{TIMEOUT, 32'd77});
        run_until("tie_done", n_results + 1, 40);
        check("tie_score", 64'(tx.res_score), 64'd77);
        check("tie_timeout", 64'(tx.res_timeout), 64'd0);

        // Back-to-back pushes with the scorer silent
        for (int i = 0; i < 6; i++) plan_q.push_back('{TIMEOUT + 5, 32'd0});
        for (int i = 0; i < 5; i++) src_q.push_back(rand_rec());
        repeat (5) step();
        check("b2b_all_taken", 64'(src_q.size()), 64'd0);
        check("b2b_full", 64'(tx.in_ready), 64'd0);
        src_q.push_back(rand_rec());
        repeat (5) step();
        check("b2b_sixth_held", 64'(src_q.size()), 64'd1);
        run_until("b2b_done", n_results + 6, 200);

        // Reset in the middle of DRIVE with three records queued
        for (int i = 0; i < 4; i++) begin
            src_q.push_back(rand_rec());
            plan_q.push_back('{TIMEOUT + 5, 32'd0});
        end
        repeat (6) step();
        check("pre_rst_drive", 64'(tx.out_valid), 64'd1);
        check("pre_rst_queued", 64'(exp_q.size()), 64'd3);
        rst = 1'b1;
        tx.in_valid = 1'b0;
        tx.score_valid = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(tx.out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(tx.in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("after_rst_out_valid", 64'(tx.out_valid), 64'd0);
        check("after_rst_res_valid", 64'(tx.res_valid), 64'd0);
        check("after_rst_busy", 64'(busy), 64'd0);
        check("after_rst_in_ready", 64'(tx.in_ready), 64'd1);
        check("after_rst_out_rec", 64'({tx.out_age, tx.out_iq, tx.out_shoesize}), 64'd0);
        check("after_rst_res_to", 64'(tx.res_timeout), 64'd0);
        exp_q.delete();
        src_q.delete();
        plan_q.delete();
        drive_len = 0;
        repeat (20) step();

        // Three records, the middle one times out
        src_q.push_back(rand_rec());
        src_q.push_back(rand_rec());
        src_q.push_back(rand_rec());
        plan_q.push_back('{3, 32'h1234_5678});
        plan_q.push_back('{TIMEOUT + 5, 32'd0});
        plan_q.push_back('{1, 32'hDEAD_BEEF});
        run_until("three_done", n_results + 3, 100);
`ifdef SCORE_ITEMS_TX_STATS_EN
        check("stat_sent", 64'(stat_sent), 64'd3);
        check("stat_timeouts", 64'(stat_timeouts), 64'd1);
`endif

        // Random traffic, random scorer delays, stray score strobes outside DRIVE
        noise_en = 1'b1;
        for (int i = 0; i < 40; i++) src_q.push_back(rand_rec());
        run_until("random_done", n_results + 40, 2500);
        noise_en = 1'b0;
        repeat (4) step();
        check("final_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
